secded_stream_decoder: RTL and testbench
========================================

Name: secded_stream_decoder

Overview:
- Parametrised, pipelined successor to the 8,4 combinational Hamming checker.
- Accepts extended-Hamming (SECDED) codewords of 2^M bits on a valid/ready stream.
- Emits the corrected codeword, the extracted data bits and error flags two cycles later.
- Keeps saturating single- and double-error counters, used by system status logic.

Parameters:
- M, 3: log2 of the codeword width. N = 2^M bits (M=3 gives 8; legal range 3..6).
- CNT_W, 16: width of each error counter.
- Derived localparams, not overridable: N = 2^M, K = N-M-1 data bits.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  block accepts in_code this cycle.
- in_code  input  N  received codeword; bit i is Hamming position i.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the output word.
- out_code  output  N  corrected codeword.
- out_data  output  K  data bits extracted from out_code.
- out_err  output  1  single or double error detected.
- out_dbl  output  1  uncorrectable double error.
- out_pos  output  M  corrected bit position (feature-gated, see below).
- cnt_clr  input  1  synchronous clear of both counters.
- sgl_cnt  output  CNT_W  count of corrected single errors.
- dbl_cnt  output  CNT_W  count of detected double errors.

Behaviour:
- Reset value of every output register is 0, so out_valid=0, both counters=0 and out_pos=0. in_ready is 1 out of reset.
- Code layout:
  - Position 0 holds overall parity.
  - Positions 2^j hold Hamming parity.
  - All other positions hold data, in ascending order: out_data[0] is position 3, out_data[1] is position 5, and so on.
- Stage 1 registers in_code, the syndrome (XOR of the indices of all set bits, M bits) and the overall parity (XOR of all N bits).
- Stage 2 registers the corrected word and the flags.
- Classification:
  - parity=1 → single error. Flip bit[syndrome]; syndrome 0 means bit 0 is flipped.
  - parity=0 and syndrome≠0 → double error. The code is passed through uncorrected; out_err=1, out_dbl=1.
  - Otherwise clean: out_err=0, out_dbl=0.
- Handshake:
  - Input transfer happens when in_valid & in_ready. Output transfer happens when out_valid & out_ready.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1, a combinational path from out_ready.
  - Full throughput: one word per cycle with no bubbles while out_ready=1.
  - Latency is exactly 2 cycles from input transfer to out_valid when there is no backpressure.
- Backpressure: when out_ready=0 and both stages are full, in_ready=0 and all outputs hold stable. No word is dropped or duplicated.
- Counters:
  - Increment on each output transfer that carries a single or a double error.
  - Saturate at 2^CNT_W-1.
  - cnt_clr=1 forces both counters to 0, and overrides a coincident increment (that event is not counted).
- Reset mid-stream discards all in-flight words and zeroes the counters immediately, asynchronously.

Optional Feature:
- Macro: SECDED_ERR_POS_EN.
- Defined: out_pos carries the syndrome of the word when it is a single error, and is 0 for clean or double-error words. It is registered with stage 2.
- Undefined: out_pos is tied to 0 and the syndrome is not carried into stage 2.

Decomposition:
- Package secded_pkg holds:
  - Function is_pow2.
  - Function data_pos(M, k), which returns the codeword index of data bit k.
  - Function calc_k(M).
  - An error-class typedef with values CLEAN, SGL, DBL.
- One sub-module, secded_syndrome: purely combinational, produces the syndrome and overall parity from an N-bit word. It is instantiated in stage 1.

Test Plan:
- M=3, out_ready=1, in_code=0xAA → 2 cycles later: out_code=0xAA, out_data=0xB, out_err=0, both counters 0.
- in_code=0x8A (bit 5 flipped) → out_code=0xAA, out_data=0xB, out_err=1, out_dbl=0, out_pos=5 when the macro is defined, sgl_cnt=1.
- in_code=0xAB (bit 0 flipped) → out_code=0xAA, out_err=1, out_pos=0; in_code=0xCA (bits 5 and 6 flipped) → out_code=0xCA, out_dbl=1, dbl_cnt=1.
- Stream 0xAA, 0x8A, 0xAB, 0xCA back-to-back while out_ready toggles 1,0,0,1,… → in order, no loss; in_ready=0 only while both stages are full; outputs stable while stalled.
- CNT_W=2, five 0x8A words → sgl_cnt saturates at 3; cnt_clr asserted together with a sixth error transfer → sgl_cnt=0.
- Assert rst with two words in flight → out_valid=0 and counters=0 immediately; first post-reset word appears after 2 cycles.

Source files
------------

// File: rtl/secded_pkg.sv
`default_nettype none
// ============================================================================
// Module   : secded_pkg
// Brief    : Shared types and elaboration-time helpers for the SECDED decoder.
// Revision : 1.0
// ============================================================================
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SGL   = 2'd1,
        DBL   = 2'd2
    } err_class_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int calc_k(input int m);
        return (1 << m) - m - 1;
    endfunction

    // Data bits fill the non-power-of-two positions above 0, in ascending order.
    function automatic int data_pos(input int m, input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i < (1 << m); i++) begin
            if (!is_pow2(i)) begin
                if (cnt == k) begin
                    pos = i;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded_syndrome.sv
`default_nettype none
// ============================================================================
// Module   : secded_syndrome
// Brief    : Combinational Hamming syndrome and overall parity of an N-bit word.
// Revision : 1.0
// ============================================================================
module secded_syndrome #(
    parameter int M = 3,
    localparam int N = 1 << M
) (
    input  logic [N-1:0] i_code,
    output logic [M-1:0] o_syn,
    output logic         o_par
);

    always_comb begin
        o_syn = '0;
        o_par = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_code[i]) begin
                o_syn = o_syn ^ M'(i);
            end
            o_par = o_par ^ i_code[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/secded_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : secded_stream_decoder
// Brief    : Two-stage valid/ready SECDED decoder with saturating error counters.
//            Define SECDED_ERR_POS_EN to report the corrected bit position.
// Revision : 1.0
// ============================================================================
module secded_stream_decoder
    import secded_pkg::*;
#(
    parameter int M     = 3,
    parameter int CNT_W = 16,
    localparam int N    = 1 << M,
    localparam int K    = calc_k(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_code,
    output logic [K-1:0]     out_data,
    output logic             out_err,
    output logic             out_dbl,
    output logic [M-1:0]     out_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sgl_cnt,
    output logic [CNT_W-1:0] dbl_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_adv1;
    logic             w_adv2;
    logic [M-1:0]     w_syn;
    logic             w_par;
    err_class_e       w_cls;
    logic [N-1:0]     w_corr;
    logic             w_xfer;

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_code;
    logic [M-1:0]     r_s1_syn;
    logic             r_s1_par;

    logic             r_s2_valid;
    logic [N-1:0]     r_s2_code;
    logic             r_s2_err;
    logic             r_s2_dbl;

    logic [CNT_W-1:0] r_sgl_cnt;
    logic [CNT_W-1:0] r_dbl_cnt;

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;
    assign w_xfer   = r_s2_valid && out_ready;

    secded_syndrome #(
        .M (M)
    ) u_syndrome (
        .i_code (in_code),
        .o_syn  (w_syn),
        .o_par  (w_par)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_syn;
                r_s1_par  <= w_par;
            end
        end
    end

    always_comb begin
        w_cls = CLEAN;
        if (r_s1_par) begin
            w_cls = SGL;
        end else if (r_s1_syn != '0) begin
            w_cls = DBL;
        end
        w_corr = r_s1_code;
        if (w_cls == SGL) begin
            w_corr = r_s1_code ^ (N'(1) << r_s1_syn);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_code  <= '0;
            r_s2_err   <= 1'b0;
            r_s2_dbl   <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_code <= w_corr;
                r_s2_err  <= (w_cls != CLEAN);
                r_s2_dbl  <= (w_cls == DBL);
            end
        end
    end

`ifdef SECDED_ERR_POS_EN
    logic [M-1:0] r_s2_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_pos <= '0;
        end else if (w_adv2 && r_s1_valid) begin
            r_s2_pos <= (w_cls == SGL) ? r_s1_syn : '0;
        end
    end

    assign out_pos = r_s2_pos;
`else
    assign out_pos = '0;
`endif

    // A clear wins over an increment landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sgl_cnt <= '0;
            r_dbl_cnt <= '0;
        end else if (cnt_clr) begin
            r_sgl_cnt <= '0;
            r_dbl_cnt <= '0;
        end else if (w_xfer && r_s2_err) begin
            if (r_s2_dbl) begin
                if (r_dbl_cnt != CNT_MAX) begin
                    r_dbl_cnt <= r_dbl_cnt + 1'b1;
                end
            end else if (r_sgl_cnt != CNT_MAX) begin
                r_sgl_cnt <= r_sgl_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < K; k++) begin : g_data
        assign out_data[k] = r_s2_code[data_pos(M, k)];
    end

    assign out_valid = r_s2_valid;
    assign out_code  = r_s2_code;
    assign out_err   = r_s2_err;
    assign out_dbl   = r_s2_dbl;
    assign sgl_cnt   = r_sgl_cnt;
    assign dbl_cnt   = r_dbl_cnt;

endmodule
`default_nettype wire

// File: tb/tb_secded_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_secded_stream_decoder
// Brief    : Directed self-checking bench for secded_stream_decoder (M=3, CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_secded_stream_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_code = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_code;
    logic [3:0] out_data;
    logic       out_err;
    logic       out_dbl;
    logic [2:0] out_pos;
    logic       cnt_clr = 1'b0;
    logic [1:0] sgl_cnt;
    logic [1:0] dbl_cnt;

    int total = 0;
    int bad   = 0;

    secded_stream_decoder #(
        .M     (3),
        .CNT_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_dbl   (out_dbl),
        .out_pos   (out_pos),
        .cnt_clr   (cnt_clr),
        .sgl_cnt   (sgl_cnt),
        .dbl_cnt   (dbl_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic [7:0] ecode;
        logic [3:0] edata;
        logic       eerr;
        logic       edbl;
        logic [2:0] epos;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_pos(input logic [2:0] p);
`ifdef SECDED_ERR_POS_EN
        return p;
`else
        return (p & 3'b000);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];
    logic [7:0] sw[4]   = '{8'hAA, 8'h8A, 8'hAB, 8'hCA};
    logic [7:0] sexp[4] = '{8'hAA, 8'hAA, 8'hAA, 8'hCA};
    logic       serr[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       sdbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       rpat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int msgl;
        int mdbl;
        int acc;
        int del;
        logic       stall_prev;
        logic [7:0] prev_code;

        vecs[0] = '{8'hAA, 8'hAA, 4'hB, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{8'h8A, 8'hAA, 4'hB, 1'b1, 1'b0, 3'd5};
        vecs[2] = '{8'hAB, 8'hAA, 4'hB, 1'b1, 1'b0, 3'd0};
        vecs[3] = '{8'hCA, 8'hCA, 4'hD, 1'b1, 1'b1, 3'd0};
        vecs[4] = '{8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{8'hFF, 8'hFF, 4'hF, 1'b0, 1'b0, 3'd0};

        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sgl_cnt", sgl_cnt, 2'd0);
        chk("rst_dbl_cnt", dbl_cnt, 2'd0);
        chk("rst_out_pos", out_pos, 3'd0);
        #9 rst = 1'b0;
        tick();

        // Single words with no backpressure: latency, correction and counting.
        msgl = 0;
        mdbl = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_code  = vecs[i].code;
            tick();
            in_valid = 1'b0;
            chk("lat1_valid", out_valid, 1'b0);
            tick();
            chk("vec_valid", out_valid, 1'b1);
            chk("vec_code", out_code, vecs[i].ecode);
            chk("vec_data", out_data, vecs[i].edata);
            chk("vec_err", out_err, vecs[i].eerr);
            chk("vec_dbl", out_dbl, vecs[i].edbl);
            chk("vec_pos", out_pos, exp_pos(vecs[i].epos));
            if (vecs[i].eerr) begin
                if (vecs[i].edbl) begin
                    if (mdbl < 3) mdbl++;
                end else begin
                    if (msgl < 3) msgl++;
                end
            end
            tick();
            chk("vec_sgl_cnt", sgl_cnt, msgl);
            chk("vec_dbl_cnt", dbl_cnt, mdbl);
            chk("vec_drained", out_valid, 1'b0);
        end

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_sgl", sgl_cnt, 2'd0);
        chk("clr_dbl", dbl_cnt, 2'd0);

        // Back-to-back stream under toggling backpressure.
        acc = 0;
        del = 0;
        stall_prev = 1'b0;
        prev_code  = 8'h00;
        for (int cyc = 0; cyc < 60 && del < 4; cyc++) begin
            out_ready = rpat[cyc % 6];
            in_valid  = (acc < 4);
            if (acc < 4) in_code = sw[acc];
            #1;
            chk("strm_in_ready", in_ready, !((acc - del) == 2 && !out_ready));
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_code", out_code, prev_code);
            end
            stall_prev = out_valid && !out_ready;
            prev_code  = out_code;
            if (out_valid && out_ready) begin
                chk("strm_code", out_code, sexp[del]);
                chk("strm_err", out_err, serr[del]);
                chk("strm_dbl", out_dbl, sdbl[del]);
                del++;
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("strm_delivered", del, 4);
        chk("strm_sgl_cnt", sgl_cnt, 2'd2);
        chk("strm_dbl_cnt", dbl_cnt, 2'd1);

        // Saturation, then a clear coinciding with an error transfer.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_code  = 8'h8A;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("sat_sgl_cnt", sgl_cnt, 2'd3);
        in_valid = 1'b1;
        in_code  = 8'h8A;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_xfer_valid", out_valid, 1'b1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_xfer_sgl", sgl_cnt, 2'd0);
        tick();
        chk("clr_xfer_hold", sgl_cnt, 2'd0);

        // Asynchronous reset with two words in flight.
        in_valid = 1'b1;
        in_code  = 8'h8A;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_sgl", sgl_cnt, 2'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'hAA;
        tick();
        in_code = 8'hCA;
        tick();
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_sgl", sgl_cnt, 2'd0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_code  = 8'hCA;
        tick();
        in_valid = 1'b0;
        chk("post_rst_lat1", out_valid, 1'b0);
        tick();
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_code", out_code, 8'hCA);
        chk("post_rst_dbl", out_dbl, 1'b1);
        tick();
        chk("post_rst_dbl_cnt", dbl_cnt, 2'd1);
        chk("post_rst_drained", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
